// File: rtl/sdram_arbiter.sv
// Two-port round-robin SDRAM access arbiter with auto-refresh scheduling and postponed-refresh accounting.
// Grant and cmd_valid appear one cycle after the decision; cmd_* are held until cmd_ack, one command outstanding.
module sdram_arbiter #(
    parameter int REFRESH_INTERVAL = 1250,
    parameter int MAX_PENDING      = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ctrl_ready,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [23:0] p0_addr,
    input  logic [15:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_done,
    output logic [15:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [23:0] p1_addr,
    input  logic [15:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_done,
    output logic [15:0] p1_rdata,
    output logic        cmd_valid,
    output logic        cmd_refresh,
    output logic        cmd_we,
    output logic [23:0] cmd_addr,
    output logic [15:0] cmd_wdata,
    input  logic        cmd_ack,
    input  logic        cmd_done,
    input  logic [15:0] cmd_rdata,
    output logic        refresh_overrun
);
    localparam int            TW       = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [TW-1:0] RELOAD   = TW'(REFRESH_INTERVAL - 1);
    localparam logic [3:0]    PEND_MAX = 4'(MAX_PENDING);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_DONE} state_t;

    state_t        state_q;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    pending_q, pending_d;
    logic          overrun_q, overrun_d;
    logic          last_port_q, cur_port_q;
    logic          p0_gnt_q, p1_gnt_q, p0_done_q, p1_done_q;
    logic [15:0]   p0_rdata_q, p1_rdata_q;
    logic          cmd_valid_q, cmd_refresh_q, cmd_we_q;
    logic [23:0]   cmd_addr_q;
    logic [15:0]   cmd_wdata_q;

    logic tick, ref_ack, refresh_due, pick_p1;

    assign tick        = ctrl_ready && (timer_q == '0);
    assign ref_ack     = (state_q == S_ISSUE) && cmd_valid_q && cmd_refresh_q && cmd_ack;
    // A tick landing in IDLE counts as due so a simultaneous port request cannot overtake it.
    assign refresh_due = (pending_q != 4'd0) || tick;
    assign pick_p1     = p1_req && (!p0_req || !last_port_q);

    always_comb begin
        timer_d   = timer_q;
        pending_d = pending_q;
        overrun_d = 1'b0;
        if (!ctrl_ready) begin
            timer_d   = RELOAD;
            pending_d = 4'd0;
        end else begin
            timer_d = tick ? RELOAD : timer_q - TW'(1);
            if (tick && !ref_ack) begin
                if (pending_q == PEND_MAX) overrun_d = 1'b1;
                else                       pending_d = pending_q + 4'd1;
            end else if (!tick && ref_ack && pending_q != 4'd0) begin
                pending_d = pending_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer_q   <= RELOAD;
            pending_q <= 4'd0;
            overrun_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            last_port_q   <= 1'b1;
            cur_port_q    <= 1'b0;
            p0_gnt_q      <= 1'b0;
            p1_gnt_q      <= 1'b0;
            p0_done_q     <= 1'b0;
            p1_done_q     <= 1'b0;
            p0_rdata_q    <= 16'h0;
            p1_rdata_q    <= 16'h0;
            cmd_valid_q   <= 1'b0;
            cmd_refresh_q <= 1'b0;
            cmd_we_q      <= 1'b0;
            cmd_addr_q    <= 24'h0;
            cmd_wdata_q   <= 16'h0;
        end else begin
            p0_gnt_q  <= 1'b0;
            p1_gnt_q  <= 1'b0;
            p0_done_q <= 1'b0;
            p1_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ctrl_ready) begin
                        if (refresh_due) begin
                            cmd_refresh_q <= 1'b1;
                            cmd_valid_q   <= 1'b1;
                            state_q       <= S_ISSUE;
                        end else if (p0_req || p1_req) begin
                            cmd_refresh_q <= 1'b0;
                            cmd_valid_q   <= 1'b1;
                            cmd_we_q      <= pick_p1 ? p1_we    : p0_we;
                            cmd_addr_q    <= pick_p1 ? p1_addr  : p0_addr;
                            cmd_wdata_q   <= pick_p1 ? p1_wdata : p0_wdata;
                            cur_port_q    <= pick_p1;
                            last_port_q   <= pick_p1;
                            p0_gnt_q      <= !pick_p1;
                            p1_gnt_q      <= pick_p1;
                            state_q       <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (!ctrl_ready) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end else if (cmd_ack) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!ctrl_ready) begin
                        state_q <= S_IDLE;
                    end else if (cmd_done) begin
                        if (!cmd_refresh_q) begin
                            if (cur_port_q) begin
                                p1_done_q <= 1'b1;
                                if (!cmd_we_q) p1_rdata_q <= cmd_rdata;
                            end else begin
                                p0_done_q <= 1'b1;
                                if (!cmd_we_q) p0_rdata_q <= cmd_rdata;
                            end
                        end
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign p0_gnt          = p0_gnt_q;
    assign p1_gnt          = p1_gnt_q;
    assign p0_done         = p0_done_q;
    assign p1_done         = p1_done_q;
    assign p0_rdata        = p0_rdata_q;
    assign p1_rdata        = p1_rdata_q;
    assign cmd_valid       = cmd_valid_q;
    assign cmd_refresh     = cmd_refresh_q;
    assign cmd_we          = cmd_we_q;
    assign cmd_addr        = cmd_addr_q;
    assign cmd_wdata       = cmd_wdata_q;
    assign refresh_overrun = overrun_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: directed stimulus pushes expected events, a negedge monitor pops and compares.
module tb_sdram_arbiter;
    localparam int RI = 16;
    localparam logic [2:0] K_GNT = 3'd1, K_CMD = 3'd2, K_DONE = 3'd3, K_OVR = 3'd4;

    typedef struct packed {
        logic [2:0]  kind;
        logic        port;
        logic        we;
        logic        rf;
        logic [23:0] addr;
        logic [15:0] data;
        logic [31:0] at;
    } ev_t;

    logic clk = 1'b0, resetn, ctrl_ready;
    logic p0_req, p0_we, p1_req, p1_we;
    logic [23:0] p0_addr, p1_addr;
    logic [15:0] p0_wdata, p1_wdata;
    logic p0_gnt, p0_done, p1_gnt, p1_done;
    logic [15:0] p0_rdata, p1_rdata;
    logic cmd_valid, cmd_refresh, cmd_we, cmd_ack, cmd_done, refresh_overrun;
    logic [23:0] cmd_addr;
    logic [15:0] cmd_wdata, cmd_rdata;

    int   total = 0, bad = 0, cyc = 0, base = 0;
    int   ack_dly = 0, done_dly = 1;
    bit   ack_en = 1'b1;
    ev_t  sb[$];

    sdram_arbiter #(.REFRESH_INTERVAL(RI), .MAX_PENDING(8)) dut (
        .clk(clk), .resetn(resetn), .ctrl_ready(ctrl_ready),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
        .cmd_valid(cmd_valid), .cmd_refresh(cmd_refresh), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_ack(cmd_ack),
        .cmd_done(cmd_done), .cmd_rdata(cmd_rdata), .refresh_overrun(refresh_overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(input logic [2:0] k, input logic p, input logic w, input logic r,
                               input logic [23:0] a, input logic [15:0] d, input logic [31:0] t);
        ev_t e;
        e.kind = k; e.port = p; e.we = w; e.rf = r; e.addr = a; e.data = d; e.at = t;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic see(input ev_t a, input string nm);
        ev_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s unexpected act=%h", nm, a);
        end else begin
            e = sb.pop_front();
            if (e.at == 32'd0) a.at = '0;
            if (e.kind == K_DONE && e.we) begin
                a.we   = 1'b1;
                a.data = e.data;
            end
            if (a !== e) begin
                bad++;
                $display("FAIL %s act=%h exp=%h", nm, a, e);
            end
        end
    endtask

    // Monitor: every DUT-visible event must match the head of the expectation queue.
    always @(negedge clk) begin
        if (p0_gnt) see(mk(K_GNT, 1'b0, 1'b0, 1'b0, 24'h0, 16'h0, 32'(cyc)), "p0_gnt");
        if (p1_gnt) see(mk(K_GNT, 1'b1, 1'b0, 1'b0, 24'h0, 16'h0, 32'(cyc)), "p1_gnt");
        if (cmd_valid && cmd_ack) begin
            if (cmd_refresh) see(mk(K_CMD, 1'b0, 1'b0, 1'b1, 24'h0, 16'h0, 32'(cyc)), "cmd_ref");
            else             see(mk(K_CMD, 1'b0, cmd_we, 1'b0, cmd_addr, cmd_wdata, 32'(cyc)), "cmd_acc");
        end
        if (p0_done) see(mk(K_DONE, 1'b0, 1'b0, 1'b0, 24'h0, p0_rdata, 32'(cyc)), "p0_done");
        if (p1_done) see(mk(K_DONE, 1'b1, 1'b0, 1'b0, 24'h0, p1_rdata, 32'(cyc)), "p1_done");
        if (refresh_overrun) see(mk(K_OVR, 1'b0, 1'b0, 1'b0, 24'h0, 16'h0, 32'(cyc)), "overrun");
    end

    // Controller model: ack ack_dly cycles after cmd_valid, done done_dly cycles after ack.
    initial begin
        int rs, cnt;
        rs = 0; cnt = 0;
        cmd_ack = 1'b0; cmd_done = 1'b0; cmd_rdata = 16'h0;
        forever begin
            @(posedge clk); #1;
            cmd_ack = 1'b0; cmd_done = 1'b0;
            if (!resetn || !ctrl_ready) rs = 0;
            else case (rs)
                0: if (cmd_valid && ack_en) begin
                       if (ack_dly == 0) begin cmd_ack = 1'b1; rs = 2; cnt = done_dly; end
                       else begin rs = 1; cnt = ack_dly; end
                   end
                1: begin
                       cnt--;
                       if (cnt == 0) begin cmd_ack = 1'b1; rs = 2; cnt = done_dly; end
                   end
                2: begin
                       cnt--;
                       if (cnt == 0) begin
                           cmd_done = 1'b1;
                           cmd_rdata = cmd_addr[15:0] ^ 16'h9DAA;
                           rs = 0;
                       end
                   end
                default: rs = 0;
            endcase
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_gnts(input int n, input string nm);
        int seen = 0;
        for (int i = 0; i < 200 && seen < n; i++) begin
            step(1);
            if (p0_gnt || p1_gnt) seen++;
        end
        chk(nm, 64'(seen), 64'(n));
    endtask

    task automatic drain(input string nm);
        int i = 0;
        while (sb.size() != 0 && i < 300) begin
            step(1);
            i++;
        end
        chk(nm, 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; ctrl_ready = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = 24'h0; p0_wdata = 16'h0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = 24'h0; p1_wdata = 16'h0;
        step(3);
        chk("rst_ports", 64'({p0_gnt, p0_done, p0_rdata, p1_gnt, p1_done, p1_rdata}), 64'd0);
        chk("rst_cmd", 64'({cmd_valid, cmd_refresh, cmd_we, cmd_addr, cmd_wdata, refresh_overrun}), 64'd0);
        resetn = 1'b1;
        step(2);

        // Round robin: both held, p0 wins the first tie after reset.
        ack_dly = 0; done_dly = 1; ack_en = 1'b1;
        p0_we = 1'b0; p0_addr = 24'h30F0F0; p0_wdata = 16'h0000;
        p1_we = 1'b1; p1_addr = 24'h801234; p1_wdata = 16'hCAFE;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(mk(K_GNT,  1'b0, 1'b0, 1'b0, 24'h0, 16'h0, 32'd0));
            sb.push_back(mk(K_CMD,  1'b0, 1'b0, 1'b0, 24'h30F0F0, 16'h0000, 32'd0));
            sb.push_back(mk(K_DONE, 1'b0, 1'b0, 1'b0, 24'h0, 16'h6D5A, 32'd0));
            sb.push_back(mk(K_GNT,  1'b1, 1'b0, 1'b0, 24'h0, 16'h0, 32'd0));
            sb.push_back(mk(K_CMD,  1'b0, 1'b1, 1'b0, 24'h801234, 16'hCAFE, 32'd0));
            sb.push_back(mk(K_DONE, 1'b1, 1'b1, 1'b0, 24'h0, 16'h0, 32'd0));
        end
        p0_req = 1'b1; p1_req = 1'b1; ctrl_ready = 1'b1;
        wait_gnts(4, "rr_gnts");
        p0_req = 1'b0; p1_req = 1'b0;
        drain("rr_drain");
        ctrl_ready = 1'b0;
        step(3);

        // Single p0 read; inputs change after grant but latched fields must hold.
        ack_dly = 1; done_dly = 3;
        p0_we = 1'b0; p0_addr = 24'h012345; p0_wdata = 16'h1111;
        sb.push_back(mk(K_GNT,  1'b0, 1'b0, 1'b0, 24'h0, 16'h0, 32'd0));
        sb.push_back(mk(K_CMD,  1'b0, 1'b0, 1'b0, 24'h012345, 16'h1111, 32'd0));
        sb.push_back(mk(K_DONE, 1'b0, 1'b0, 1'b0, 24'h0, 16'hBEEF, 32'd0));
        p0_req = 1'b1; ctrl_ready = 1'b1;
        wait_gnts(1, "rd_gnt");
        p0_req = 1'b0; p0_addr = 24'hFFFFFF; p0_wdata = 16'hDEAD;
        drain("rd_drain");
        ctrl_ready = 1'b0;
        step(3);
        chk("p0_rdata_hold", 64'(p0_rdata), 64'h BEEF);
        chk("p1_rdata_quiet", 64'(p1_rdata), 64'h0);

        // Refresh every RI cycles; p0 asserting in a tick cycle is served after that refresh.
        ack_dly = 0; done_dly = 2;
        ctrl_ready = 1'b1; base = cyc;
        for (int k = 1; k <= 4; k++)
            sb.push_back(mk(K_CMD, 1'b0, 1'b0, 1'b1, 24'h0, 16'h0, 32'(base + 16 * k)));
        sb.push_back(mk(K_GNT,  1'b0, 1'b0, 1'b0, 24'h0, 16'h0, 32'(base + 68)));
        sb.push_back(mk(K_CMD,  1'b0, 1'b1, 1'b0, 24'h2ABCDE, 16'h5555, 32'(base + 68)));
        sb.push_back(mk(K_DONE, 1'b0, 1'b1, 1'b0, 24'h0, 16'h0, 32'd0));
        step(63);
        p0_we = 1'b1; p0_addr = 24'h2ABCDE; p0_wdata = 16'h5555; p0_req = 1'b1;
        wait_gnts(1, "ref_gnt");
        p0_req = 1'b0;
        drain("ref_drain");
        ctrl_ready = 1'b0;
        step(3);

        // Saturation: no acks, the 9th and 10th ticks overrun.
        ack_en = 1'b0;
        ctrl_ready = 1'b1; base = cyc;
        sb.push_back(mk(K_OVR, 1'b0, 1'b0, 1'b0, 24'h0, 16'h0, 32'(base + 144)));
        sb.push_back(mk(K_OVR, 1'b0, 1'b0, 1'b0, 24'h0, 16'h0, 32'(base + 160)));
        step(170);
        chk("pend_sat", 64'(dut.pending_q), 64'd8);
        chk("ovr_seen", 64'(sb.size()), 64'd0);
        ctrl_ready = 1'b0;
        step(1);
        chk("pend_clr", 64'(dut.pending_q), 64'd0);
        chk("sat_valid_off", 64'(cmd_valid), 64'd0);
        ack_en = 1'b1;
        step(2);

        // ctrl_ready drop during a p1 write in WAIT_DONE: abort, no done, re-grant later.
        ack_dly = 0; done_dly = 20;
        p1_we = 1'b1; p1_addr = 24'hC00AB0; p1_wdata = 16'h1357;
        sb.push_back(mk(K_GNT, 1'b1, 1'b0, 1'b0, 24'h0, 16'h0, 32'd0));
        sb.push_back(mk(K_CMD, 1'b0, 1'b1, 1'b0, 24'hC00AB0, 16'h1357, 32'd0));
        p1_req = 1'b1; ctrl_ready = 1'b1;
        wait_gnts(1, "ab_gnt");
        step(3);
        ctrl_ready = 1'b0;
        step(1);
        chk("ab_valid_off", 64'(cmd_valid), 64'd0);
        chk("ab_pend", 64'(dut.pending_q), 64'd0);
        step(8);
        drain("ab_drain");
        done_dly = 1;
        sb.push_back(mk(K_GNT,  1'b1, 1'b0, 1'b0, 24'h0, 16'h0, 32'd0));
        sb.push_back(mk(K_CMD,  1'b0, 1'b1, 1'b0, 24'hC00AB0, 16'h1357, 32'd0));
        sb.push_back(mk(K_DONE, 1'b1, 1'b1, 1'b0, 24'h0, 16'h0, 32'd0));
        ctrl_ready = 1'b1;
        wait_gnts(1, "ab_regnt");
        p1_req = 1'b0;
        drain("ab_redrain");
        ctrl_ready = 1'b0;
        step(3);

        // Reset while in ISSUE after a p0 grant; afterwards p0 still wins the tie.
        ack_en = 1'b0;
        p0_we = 1'b0; p0_addr = 24'h000001;
        sb.push_back(mk(K_GNT, 1'b0, 1'b0, 1'b0, 24'h0, 16'h0, 32'd0));
        p0_req = 1'b1; ctrl_ready = 1'b1;
        wait_gnts(1, "ri_gnt");
        p0_req = 1'b0;
        step(3);
        #3 resetn = 1'b0;
        #1;
        chk("ri_ports", 64'({p0_gnt, p0_done, p0_rdata, p1_gnt, p1_done, p1_rdata}), 64'd0);
        chk("ri_cmd", 64'({cmd_valid, cmd_refresh, cmd_we, cmd_addr, cmd_wdata, refresh_overrun}), 64'd0);
        drain("ri_pre");
        step(1);
        ack_en = 1'b1; ack_dly = 0; done_dly = 1;
        p0_we = 1'b0; p0_addr = 24'h120F00;
        p1_we = 1'b1; p1_addr = 24'h345678; p1_wdata = 16'h2468;
        sb.push_back(mk(K_GNT,  1'b0, 1'b0, 1'b0, 24'h0, 16'h0, 32'd0));
        sb.push_back(mk(K_CMD,  1'b0, 1'b0, 1'b0, 24'h120F00, 16'h0000, 32'd0));
        sb.push_back(mk(K_DONE, 1'b0, 1'b0, 1'b0, 24'h0, 16'h92AA, 32'd0));
        sb.push_back(mk(K_GNT,  1'b1, 1'b0, 1'b0, 24'h0, 16'h0, 32'd0));
        sb.push_back(mk(K_CMD,  1'b0, 1'b1, 1'b0, 24'h345678, 16'h2468, 32'd0));
        sb.push_back(mk(K_DONE, 1'b1, 1'b1, 1'b0, 24'h0, 16'h0, 32'd0));
        p0_wdata = 16'h0000;
        resetn = 1'b1; p0_req = 1'b1; p1_req = 1'b1;
        wait_gnts(2, "ri_gnts");
        p0_req = 1'b0; p1_req = 1'b0;
        drain("ri_drain");
        ctrl_ready = 1'b0;
        step(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
